// File: rtl/ram_sp_req_arb.sv
// Round-robin arbiter that serializes write and read requests onto one RAM port,
// plus a 2-entry FIFO that absorbs the RAM's registered read latency.
module ram_sp_req_arb #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [ADDR_BITS-1:0]   wr_addr_i,
  input  logic [DATA_BITS/8-1:0] wr_strb_i,
  input  logic [DATA_BITS-1:0]   wr_data_i,
  input  logic                   rd_valid_i,
  output logic                   rd_ready_o,
  input  logic [ADDR_BITS-1:0]   rd_addr_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_BITS-1:0]   rsp_data_o,
  output logic                   ram_en_o,
  output logic [DATA_BITS/8-1:0] ram_we_o,
  output logic [ADDR_BITS-1:0]   ram_addr_o,
  output logic [DATA_BITS-1:0]   ram_data_o,
  input  logic [DATA_BITS-1:0]   ram_data_i,
  output logic                   idle_o
);

  localparam int STRB_BITS = DATA_BITS / 8;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid must not depend on ready, while ready may depend combinationally on valid.
  logic                 prio_rd;
  logic                 inflight;
  logic [1:0]           count;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [DATA_BITS-1:0] fifo_mem [2];

  logic       pop;
  logic       push;
  logic       rd_ok;
  logic       wr_req;
  logic       rd_req;
  logic       grant_wr;
  logic       grant_rd;
  logic [2:0] occupancy;

  always_comb begin
    rsp_valid_o = rstn_i && (count != 2'd0);
    rsp_data_o  = fifo_mem[rd_ptr];
    idle_o      = !rstn_i || (!inflight && (count == 2'd0));
    pop         = rsp_valid_o && rsp_ready_i;
    push        = rstn_i && inflight;
    // Slots committed after this cycle: buffered + in flight - leaving now.
    occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    rd_ok       = (occupancy < 3'd2);
    wr_req      = rstn_i && wr_valid_i;
    rd_req      = rstn_i && rd_valid_i && rd_ok;
    grant_wr    = wr_req && (!rd_req || !prio_rd);
    grant_rd    = rd_req && (!wr_req || prio_rd);
    wr_ready_o  = grant_wr;
    rd_ready_o  = grant_rd;
  end

  always_comb begin
    ram_en_o   = 1'b0;
    ram_we_o   = '0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (grant_wr) begin
      ram_en_o   = 1'b1;
      ram_we_o   = wr_strb_i;
      ram_addr_o = wr_addr_i;
      ram_data_o = wr_data_i;
    end else if (grant_rd) begin
      ram_en_o   = 1'b1;
      ram_we_o   = {STRB_BITS{1'b0}};
      ram_addr_o = rd_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      prio_rd  <= 1'b0;
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (grant_wr || grant_rd) prio_rd <= grant_wr;
      inflight <= grant_rd;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible once count says so.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_data_i;
  end

endmodule

// File: tb/tb_ram_sp_req_arb.sv
// Directed bench for ram_sp_req_arb with a behavioural single-port RAM attached.
module tb_ram_sp_req_arb;
  localparam int A = 10;
  localparam int D = 64;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         rstn_i = 1'b0;
  logic         wr_valid_i = 1'b0;
  logic         wr_ready_o;
  logic [A-1:0] wr_addr_i = '0;
  logic [S-1:0] wr_strb_i = '0;
  logic [D-1:0] wr_data_i = '0;
  logic         rd_valid_i = 1'b0;
  logic         rd_ready_o;
  logic [A-1:0] rd_addr_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b1;
  logic [D-1:0] rsp_data_o;
  logic         ram_en_o;
  logic [S-1:0] ram_we_o;
  logic [A-1:0] ram_addr_o;
  logic [D-1:0] ram_data_o;
  logic [D-1:0] ram_data_i;
  logic         idle_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [D-1:0] exp_q[$];
  logic [D-1:0] mem [0:(1<<A)-1];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ram_sp_req_arb #(.ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_strb_i(wr_strb_i), .wr_data_i(wr_data_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .idle_o(idle_o)
  );

  // Single-port RAM with registered output, updated on writes as well.
  initial begin
    for (int i = 0; i < (1 << A); i++) mem[i] = '0;
  end

  always @(posedge clk) begin : ram_model
    logic [D-1:0] tmp;
    if (ram_en_o) begin
      tmp = mem[ram_addr_o];
      for (int b = 0; b < S; b++)
        if (ram_we_o[b]) tmp[b*8 +: 8] = ram_data_o[b*8 +: 8];
      mem[ram_addr_o] <= tmp;
      ram_data_i      <= tmp;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] val(input int a);
    return {32'hB0B0_0000 + 32'(a), 32'h0F0F_0000 + 32'(a)};
  endfunction

  // Invariants sampled mid-cycle: never two grants, never a push into a full FIFO.
  initial begin
    forever begin
      @(negedge clk); #2;
      check("one_grant", 64'(wr_ready_o && rd_ready_o), 64'd0);
      check("no_ovf", 64'(rstn_i && dut.inflight && dut.count == 2'd2), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    wr_valid_i = 1'b0; wr_addr_i = '0; wr_strb_i = '0; wr_data_i = '0;
    rd_valid_i = 1'b0; rd_addr_i = '0;
  endtask

  task automatic drive_wr(input logic [A-1:0] a, input logic [S-1:0] s, input logic [D-1:0] d);
    wr_valid_i = 1'b1; wr_addr_i = a; wr_strb_i = s; wr_data_i = d;
  endtask

  task automatic drive_rd(input logic [A-1:0] a);
    rd_valid_i = 1'b1; rd_addr_i = a;
  endtask

  task automatic expect_rsp(input string tag, input logic [D-1:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk); idle_in(); #1;
      if (rsp_valid_o) begin
        check(tag, rsp_data_o, exp);
        seen = 1'b1;
      end
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int n_rsp;
    logic [D-1:0] head;

    // reset holds everything quiet even with requests present
    rstn_i = 1'b0; drive_wr(10'd1, 8'hFF, 64'd1); drive_rd(10'd1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_ready", wr_ready_o, 0);
    check("rst_rd_ready", rd_ready_o, 0);
    check("rst_ram_en", ram_en_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_idle", idle_o, 1);

    // basic write then read, exact 2-cycle latency
    @(negedge clk); rstn_i = 1'b1; idle_in(); rsp_ready_i = 1'b1;
    drive_wr(10'd5, 8'hFF, 64'hDEADBEEF_01234567); #1;
    check("bw_wr_ready", wr_ready_o, 1);
    check("bw_rd_ready", rd_ready_o, 0);
    check("bw_ram_en", ram_en_o, 1);
    check("bw_ram_we", ram_we_o, 8'hFF);
    check("bw_ram_addr", ram_addr_o, 5);
    check("bw_ram_data", ram_data_o, 64'hDEADBEEF_01234567);
    @(negedge clk); idle_in(); drive_rd(10'd5); #1;
    check("br_rd_ready", rd_ready_o, 1);
    check("br_ram_we", ram_we_o, 0);
    check("br_ram_addr", ram_addr_o, 5);
    check("br_ram_data", ram_data_o, 0);
    @(negedge clk); idle_in(); #1;
    check("br_t1_valid", rsp_valid_o, 0);
    check("br_t1_idle", idle_o, 0);
    check("br_t1_ram_en", ram_en_o, 0);
    @(negedge clk); #1;
    check("br_t2_valid", rsp_valid_o, 1);
    check("br_t2_data", rsp_data_o, 64'hDEADBEEF_01234567);
    @(negedge clk); #1;
    check("br_t3_valid", rsp_valid_o, 0);
    check("br_t3_idle", idle_o, 1);

    // byte strobes, including a zero-strobe write that still takes the port
    @(negedge clk); idle_in(); drive_wr(10'd3, 8'hFF, {64{1'b1}}); #1;
    check("st_w0", wr_ready_o, 1);
    @(negedge clk); idle_in(); drive_wr(10'd3, 8'h0F, 64'd0); #1;
    check("st_w1", wr_ready_o, 1);
    check("st_w1_we", ram_we_o, 8'h0F);
    @(negedge clk); idle_in(); drive_wr(10'd3, 8'h00, 64'd0); #1;
    check("st_w2_ready", wr_ready_o, 1);
    check("st_w2_en", ram_en_o, 1);
    check("st_w2_we", ram_we_o, 0);
    @(negedge clk); idle_in(); drive_rd(10'd3); #1;
    check("st_rd_ready", rd_ready_o, 1);
    expect_rsp("st_data", 64'hFFFFFFFF_00000000);

    // leave write as last grant, then reset: arbitration must restart write-first
    @(negedge clk); idle_in(); drive_wr(10'd2, 8'hFF, 64'h2); #1;
    check("rr_pre_w", wr_ready_o, 1);
    @(negedge clk); idle_in(); rstn_i = 1'b0;
    @(negedge clk); rstn_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      drive_wr(10'(20 + i), 8'hFF, 64'(i)); drive_rd(10'(40 + i)); #1;
      check($sformatf("rr_w%0d", i), wr_ready_o, 64'((i % 2) == 0));
      check($sformatf("rr_r%0d", i), rd_ready_o, 64'((i % 2) == 1));
      check($sformatf("rr_en%0d", i), ram_en_o, 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_in();
    end
    #1;
    check("rr_drained_idle", idle_o, 1);

    // backpressure with scoreboard; preload distinct data
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); idle_in(); drive_wr(10'(100 + k), 8'hFF, val(100 + k));
    end
    @(negedge clk); idle_in(); rsp_ready_i = 1'b0; drive_rd(10'd100); #1;
    check("bp_acc0", rd_ready_o, 1);
    exp_q.push_back(val(100));
    @(negedge clk); drive_rd(10'd101); #1;
    check("bp_acc1", rd_ready_o, 1);
    exp_q.push_back(val(101));
    @(negedge clk); drive_rd(10'd102); #1;
    check("bp_stall0", rd_ready_o, 0);
    check("bp_valid", rsp_valid_o, 1);
    check("bp_head", rsp_data_o, val(100));
    @(negedge clk); #1;
    check("bp_stall1", rd_ready_o, 0);
    check("bp_hold", rsp_data_o, val(100));
    a = 102;
    n_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); rsp_ready_i = 1'b1;
      if (a <= 105) drive_rd(10'(a)); else idle_in();
      #1;
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_rsp", rsp_data_o, 64'd0 - 64'd1);
        end else begin
          head = exp_q.pop_front();
          check("bp_rsp", rsp_data_o, head);
        end
        n_rsp++;
      end
      if (a <= 105) begin
        check("bp_tput", rd_ready_o, 1);
        if (rd_ready_o) begin
          exp_q.push_back(val(a));
          a++;
        end
      end
    end
    check("bp_rsp_count", 64'(n_rsp), 64'd6);
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);
    check("bp_idle", idle_o, 1);

    // same-address race, write priority then read priority
    @(negedge clk); idle_in(); drive_wr(10'd7, 8'hFF, 64'h55); #1;
    check("rc_init_w", wr_ready_o, 1);
    @(negedge clk); idle_in(); drive_rd(10'd7); #1;
    check("rc_init_r", rd_ready_o, 1);
    expect_rsp("rc_init_data", 64'h55);
    @(negedge clk); idle_in(); drive_wr(10'd7, 8'hFF, 64'hAA); drive_rd(10'd7); #1;
    check("rc0_w", wr_ready_o, 1);
    check("rc0_r", rd_ready_o, 0);
    @(negedge clk); idle_in(); drive_rd(10'd7); #1;
    check("rc0_r2", rd_ready_o, 1);
    expect_rsp("rc0_data", 64'hAA);
    @(negedge clk); idle_in(); drive_wr(10'd7, 8'hFF, 64'h55); #1;
    check("rc1_pre_w", wr_ready_o, 1);
    @(negedge clk); idle_in(); drive_wr(10'd7, 8'hFF, 64'hAA); drive_rd(10'd7); #1;
    check("rc1_r", rd_ready_o, 1);
    check("rc1_w", wr_ready_o, 0);
    @(negedge clk); idle_in(); drive_wr(10'd7, 8'hFF, 64'hAA); #1;
    check("rc1_w2", wr_ready_o, 1);
    expect_rsp("rc1_data", 64'h55);

    // reset one cycle after a read accept drops that read
    @(negedge clk); idle_in(); drive_rd(10'd7); #1;
    check("mr_acc", rd_ready_o, 1);
    @(negedge clk); rstn_i = 1'b0; drive_wr(10'd9, 8'hFF, 64'h9); #1;
    check("mr_rst_valid", rsp_valid_o, 0);
    check("mr_rst_idle", idle_o, 1);
    check("mr_rst_wr", wr_ready_o, 0);
    check("mr_rst_rd", rd_ready_o, 0);
    check("mr_rst_en", ram_en_o, 0);
    @(negedge clk); rstn_i = 1'b1; drive_wr(10'd9, 8'hFF, 64'h9); drive_rd(10'd9); #1;
    check("mr_post_valid", rsp_valid_o, 0);
    check("mr_post_idle", idle_o, 1);
    check("mr_post_w", wr_ready_o, 1);
    check("mr_post_r", rd_ready_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle_in(); #1;
      check("mr_no_ghost", rsp_valid_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
